// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer
// Owns the program counter for a single-cycle-read instruction memory,
// registers each fetched word (with its PC) into a one-entry output stage,
// and hands it to decode over a valid/ready handshake. Also handles
// start/halt control, branch/jump redirects, an out-of-range fault and a
// count of retired fetches.
//
// Handshake: InstrValid is asserted while the output stage holds an entry
// and is never withdrawn until the entry is taken. InstrOut and InstrPC stay
// stable while InstrValid=1 and InstrReady=0. The entry is taken on a rising
// edge where InstrValid && InstrReady; a redirect is the only event that
// discards an entry without that handshake.
module imem_fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Halt,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] InstrOut,
    output logic [31:0] InstrPC,
    output logic        Busy,
    output logic        FetchFault,
    output logic [31:0] FetchCount,
    output logic [1:0]  debug_state
);

    // First byte address past the end of the instruction memory.
    localparam logic [31:0] PC_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] redirect_pc;
    logic        pc_in_range;
    logic        slot_free;
    logic        handshake;
    logic        load;
    logic        fault_set;
    logic [1:0]  unused_target_lsbs;

    // Instruction addresses are word aligned; the low target bits carry no
    // information and are dropped.
    assign redirect_pc        = {RedirectTarget[31:2], 2'b00};
    assign unused_target_lsbs = RedirectTarget[1:0];

    assign pc_in_range = (pc < PC_LIMIT);
    assign slot_free   = !InstrValid || InstrReady;
    assign handshake   = InstrValid && InstrReady;

    // Next-state and load/fault decisions; Halt outranks Start, and a
    // redirect suppresses both the load and the range check for that cycle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        fault_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start && !Halt) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (Halt) begin
                    state_next = ST_HALTED;
                end else if (!RedirectValid && !pc_in_range) begin
                    state_next = ST_HALTED;
                    fault_set  = 1'b1;
                end else begin
                    // Reaching here without a redirect implies pc is in range.
                    load = slot_free && !RedirectValid;
                end
            end
            ST_HALTED: begin
                if (Start && !Halt && !FetchFault) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Program counter: a redirect wins over the sequential advance.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc <= RESET_PC;
        end else if (RedirectValid) begin
            pc <= redirect_pc;
        end else if (load) begin
            pc <= pc + 32'd4;
        end
    end

    // Output stage valid flag: flush on redirect, set on load, clear on take.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            InstrValid <= 1'b0;
        end else if (RedirectValid) begin
            InstrValid <= 1'b0;
        end else if (load) begin
            InstrValid <= 1'b1;
        end else if (handshake) begin
            InstrValid <= 1'b0;
        end
    end

    // Output stage payload: only written by a load, so it holds under stall.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            InstrOut <= 32'd0;
            InstrPC  <= 32'd0;
        end else if (load) begin
            InstrOut <= ImemInstruction;
            InstrPC  <= pc;
        end
    end

    // Sticky out-of-range fault; only Reset clears it.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            FetchFault <= 1'b0;
        end else if (fault_set) begin
            FetchFault <= 1'b1;
        end
    end

    // Retired-fetch counter; counts every completed handshake, wrapping.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            FetchCount <= 32'd0;
        end else if (handshake) begin
            FetchCount <= FetchCount + 32'd1;
        end
    end

    assign ImemAddress = pc;
    assign Busy        = (state == ST_FETCH);
    assign debug_state = state;

endmodule
